// File: rtl/memshare_alloc_sched_pkg.sv
// Shared memShare configuration: DRC stage indices, scheduler state encoding
// and the request register layout used by the allocation-sequence scheduler.
package memShare_config_pkg;

   localparam int unsigned MEMSHARE_DRC1    = 0;
   localparam int unsigned MEMSHARE_DRC2    = 1;
   localparam int unsigned MEMSHARE_DRC3    = 2;
   localparam int unsigned MEMSHARE_DRC_NUM = 3;

   localparam int unsigned MEMSHARE_SHIFT_W = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT_GEN,
      SEQ1,
      BUBBLE
   } memshare_sched_state_e;

   typedef struct packed {
      logic [MEMSHARE_SHIFT_W-1:0] shift;
      logic                        gtr;
   } memshare_rqst_t;

   // Adding half the shift range modulo 2^W only flips the MSB.
   function automatic logic [MEMSHARE_SHIFT_W-1:0] memshare_half_turn(
      input logic [MEMSHARE_SHIFT_W-1:0] s
   );
      return s ^ {1'b1, {(MEMSHARE_SHIFT_W-1){1'b0}}};
   endfunction

endpackage

// File: rtl/memshare_alloc_sched_cycle_cnt.sv
// Pipeline-cycle counter and per-pipeline-cycle sequence counter for the
// memShare allocation scheduler.
module memshare_cycle_cnt #(
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned SEQ_CNT_W = 3
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_pipe_begin,
   input  logic                 i_alloc_hs,
   output logic [CNT_W-1:0]     o_pipe_cycle_cnt,
   output logic [SEQ_CNT_W-1:0] o_seq_cnt
);

   localparam logic [SEQ_CNT_W-1:0] SEQ_MAX = '1;

   logic [CNT_W-1:0]     r_pipe_cnt;
   logic [SEQ_CNT_W-1:0] r_seq_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pipe_cnt <= '0;
         r_seq_cnt  <= '0;
      end else begin
         if (i_pipe_begin) begin
            r_pipe_cnt <= r_pipe_cnt + CNT_W'(1);
         end
         // A handshake in the same cycle as a new pipeline cycle belongs to the new one.
         if (i_pipe_begin) begin
            r_seq_cnt <= i_alloc_hs ? SEQ_CNT_W'(1) : '0;
         end else if (i_alloc_hs && (r_seq_cnt != SEQ_MAX)) begin
            r_seq_cnt <= r_seq_cnt + SEQ_CNT_W'(1);
         end
      end
   end

   assign o_pipe_cycle_cnt = r_pipe_cnt;
   assign o_seq_cnt        = r_seq_cnt;

endmodule

// File: rtl/memshare_alloc_sched.sv
// Allocation-sequence scheduler for SCU.memShare(): turns shift requests into
// one or two allocation sequences and drives memShare_monitor.isGtr_i.
module memshare_alloc_sched
   import memShare_config_pkg::*;
#(
   parameter int unsigned SHIFT_W   = MEMSHARE_SHIFT_W,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned SEQ_CNT_W = 3
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic                        rqst_valid_i,
   output logic                        rqst_ready_o,
   input  logic [SHIFT_W-1:0]          rqst_shift_i,
   input  logic                        rqst_gtr_i,
   output logic                        alloc_valid_o,
   input  logic                        alloc_ready_i,
   output logic [SHIFT_W-1:0]          alloc_shift_o,
   output logic                        alloc_seq_o,
   output logic                        alloc_last_o,
   output logic                        isGtr_o,
   input  logic [MEMSHARE_DRC_NUM-1:0] is_drc_i,
   input  logic                        pipeCycle_begin_i,
   output logic [CNT_W-1:0]            pipe_cycle_cnt_o,
   output logic [SEQ_CNT_W-1:0]        seq_cnt_o
);

   memshare_sched_state_e r_state;
   memshare_sched_state_e w_next;
   memshare_rqst_t        r_rqst;

   logic w_drc2;
   logic w_rqst_hs;
   logic w_alloc_hs;
   logic w_unused_drc;

   assign w_drc2       = is_drc_i[MEMSHARE_DRC2];
   assign w_unused_drc = is_drc_i[MEMSHARE_DRC1] ^ is_drc_i[MEMSHARE_DRC3];

   always_comb begin
      w_next        = r_state;
      rqst_ready_o  = 1'b0;
      alloc_valid_o = 1'b0;
      alloc_seq_o   = 1'b0;
      alloc_last_o  = 1'b0;
      alloc_shift_o = '0;
      isGtr_o       = 1'b0;
      case (r_state)
         IDLE: begin
            rqst_ready_o = 1'b1;
            if (rqst_valid_i) begin
               w_next = SHIFT_GEN;
            end
         end
         SHIFT_GEN: begin
            alloc_valid_o = 1'b1;
            alloc_shift_o = r_rqst.shift;
            alloc_last_o  = ~r_rqst.gtr;
            rqst_ready_o  = alloc_ready_i & ~r_rqst.gtr;
            if (alloc_ready_i) begin
               isGtr_o = r_rqst.gtr;
               if (r_rqst.gtr) begin
                  w_next = SEQ1;
               end else if (rqst_valid_i) begin
                  w_next = SHIFT_GEN;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         SEQ1: begin
            alloc_valid_o = 1'b1;
            alloc_seq_o   = 1'b1;
            alloc_last_o  = 1'b1;
            alloc_shift_o = memshare_half_turn(r_rqst.shift);
            rqst_ready_o  = alloc_ready_i & ~w_drc2;
            if (alloc_ready_i) begin
               if (w_drc2) begin
                  w_next = BUBBLE;
               end else if (rqst_valid_i) begin
                  w_next = SHIFT_GEN;
               end else begin
                  w_next = IDLE;
               end
            end
         end
         BUBBLE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
      // Refuse new work while reset is applied so nothing is latched across it.
      if (rst) begin
         rqst_ready_o = 1'b0;
      end
   end

   assign w_rqst_hs  = rqst_valid_i & rqst_ready_o;
   assign w_alloc_hs = alloc_valid_o & alloc_ready_i;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_rqst  <= '0;
      end else begin
         r_state <= w_next;
         if (w_rqst_hs) begin
            r_rqst <= '{shift: rqst_shift_i, gtr: rqst_gtr_i};
         end
      end
   end

   memshare_cycle_cnt #(
      .CNT_W     (CNT_W),
      .SEQ_CNT_W (SEQ_CNT_W)
   ) u_cycle_cnt (
      .i_clk            (sys_clk),
      .i_rst            (rst),
      .i_pipe_begin     (pipeCycle_begin_i),
      .i_alloc_hs       (w_alloc_hs),
      .o_pipe_cycle_cnt (pipe_cycle_cnt_o),
      .o_seq_cnt        (seq_cnt_o)
   );

endmodule

// File: tb/tb_memshare_alloc_sched.sv
// Directed self-checking bench for memshare_alloc_sched.
module tb_memshare_alloc_sched;
   import memShare_config_pkg::*;

   localparam int unsigned SHIFT_W   = 5;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned SEQ_CNT_W = 3;

   logic                        sys_clk = 1'b0;
   logic                        rst;
   logic                        rqst_valid_i;
   logic                        rqst_ready_o;
   logic [SHIFT_W-1:0]          rqst_shift_i;
   logic                        rqst_gtr_i;
   logic                        alloc_valid_o;
   logic                        alloc_ready_i;
   logic [SHIFT_W-1:0]          alloc_shift_o;
   logic                        alloc_seq_o;
   logic                        alloc_last_o;
   logic                        isGtr_o;
   logic [MEMSHARE_DRC_NUM-1:0] is_drc_i;
   logic                        pipeCycle_begin_i;
   logic [CNT_W-1:0]            pipe_cycle_cnt_o;
   logic [SEQ_CNT_W-1:0]        seq_cnt_o;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 sys_clk = ~sys_clk;

   memshare_alloc_sched #(
      .SHIFT_W   (SHIFT_W),
      .CNT_W     (CNT_W),
      .SEQ_CNT_W (SEQ_CNT_W)
   ) dut (
      .sys_clk           (sys_clk),
      .rst               (rst),
      .rqst_valid_i      (rqst_valid_i),
      .rqst_ready_o      (rqst_ready_o),
      .rqst_shift_i      (rqst_shift_i),
      .rqst_gtr_i        (rqst_gtr_i),
      .alloc_valid_o     (alloc_valid_o),
      .alloc_ready_i     (alloc_ready_i),
      .alloc_shift_o     (alloc_shift_o),
      .alloc_seq_o       (alloc_seq_o),
      .alloc_last_o      (alloc_last_o),
      .isGtr_o           (isGtr_o),
      .is_drc_i          (is_drc_i),
      .pipeCycle_begin_i (pipeCycle_begin_i),
      .pipe_cycle_cnt_o  (pipe_cycle_cnt_o),
      .seq_cnt_o         (seq_cnt_o)
   );

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   // Checks every alloc-side output of the current cycle.
   task automatic chk_alloc(input string tag, input logic v, input logic [SHIFT_W-1:0] sh,
                            input logic sq, input logic la, input logic g);
      chk({tag, "_valid"}, 32'(alloc_valid_o), 32'(v));
      chk({tag, "_shift"}, 32'(alloc_shift_o), 32'(sh));
      chk({tag, "_seq"},   32'(alloc_seq_o),   32'(sq));
      chk({tag, "_last"},  32'(alloc_last_o),  32'(la));
      chk({tag, "_isgtr"}, 32'(isGtr_o),       32'(g));
   endtask

   initial begin
      rst = 1'b1; rqst_valid_i = 1'b0; rqst_shift_i = '0; rqst_gtr_i = 1'b0;
      alloc_ready_i = 1'b1; is_drc_i = '0; pipeCycle_begin_i = 1'b0;
      tick(); tick();
      chk_alloc("rst", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("rst_rdy",  32'(rqst_ready_o), 32'd0);
      chk("rst_pipe", 32'(pipe_cycle_cnt_o), 32'd0);
      chk("rst_seqc", 32'(seq_cnt_o), 32'd0);
      rst = 1'b0; #1;
      chk("idle_rdy", 32'(rqst_ready_o), 32'd1);

      // Test 1: single non-gtr request
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd3; rqst_gtr_i = 1'b0; #1;
      chk("t1_pre_valid", 32'(alloc_valid_o), 32'd0);
      tick(); rqst_valid_i = 1'b0; #1;
      chk_alloc("t1", 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
      tick();
      chk("t1_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t1_idle_rdy", 32'(rqst_ready_o), 32'd1);
      chk("t1_seqc", 32'(seq_cnt_o), 32'd1);

      // Test 2: gtr request, two sequences
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd3; rqst_gtr_i = 1'b1;
      tick(); rqst_valid_i = 1'b0; #1;
      chk_alloc("t2_s0", 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
      chk("t2_s0_rdy", 32'(rqst_ready_o), 32'd0);
      tick();
      chk_alloc("t2_s1", 1'b1, 5'd19, 1'b1, 1'b1, 1'b0);
      tick();
      chk("t2_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t2_seqc", 32'(seq_cnt_o), 32'd3);

      // Test 4: stall in SEQ1 for 3 cycles
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd3; rqst_gtr_i = 1'b1;
      tick(); rqst_valid_i = 1'b0;
      tick(); alloc_ready_i = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         chk_alloc("t4_stall", 1'b1, 5'd19, 1'b1, 1'b1, 1'b0);
         chk("t4_stall_rdy", 32'(rqst_ready_o), 32'd0);
         tick();
      end
      alloc_ready_i = 1'b1; #1;
      chk_alloc("t4_rel", 1'b1, 5'd19, 1'b1, 1'b1, 1'b0);
      tick();
      chk("t4_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t4_seqc", 32'(seq_cnt_o), 32'd5);

      // Test 3: DRC2 during SEQ1 handshake inserts one bubble
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd5; rqst_gtr_i = 1'b1;
      tick(); rqst_valid_i = 1'b0;
      tick();
      is_drc_i[MEMSHARE_DRC2] = 1'b1;
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd7; rqst_gtr_i = 1'b0; #1;
      chk_alloc("t3_s1", 1'b1, 5'd21, 1'b1, 1'b1, 1'b0);
      chk("t3_s1_rdy", 32'(rqst_ready_o), 32'd0);
      tick(); is_drc_i = '0; #1;
      chk("t3_bub_valid", 32'(alloc_valid_o), 32'd0);
      chk("t3_bub_rdy", 32'(rqst_ready_o), 32'd0);
      tick();
      chk("t3_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t3_idle_rdy", 32'(rqst_ready_o), 32'd1);
      tick(); rqst_valid_i = 1'b0; #1;
      chk_alloc("t3_resume", 1'b1, 5'd7, 1'b0, 1'b1, 1'b0);
      tick();
      chk("t3_seqc_sat", 32'(seq_cnt_o), 32'd7);

      // Back-to-back non-gtr requests, no bubble
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd1; rqst_gtr_i = 1'b0;
      tick(); rqst_shift_i = 5'd2; #1;
      chk_alloc("b2b_a", 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
      chk("b2b_a_rdy", 32'(rqst_ready_o), 32'd1);
      tick(); rqst_valid_i = 1'b0; #1;
      chk_alloc("b2b_b", 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
      tick();
      chk("b2b_idle_valid", 32'(alloc_valid_o), 32'd0);

      // Test 5: pipeline-cycle counting and sequence-counter saturation
      pipeCycle_begin_i = 1'b1;
      tick(); pipeCycle_begin_i = 1'b0; #1;
      chk("t5_p1_pipe", 32'(pipe_cycle_cnt_o), 32'd1);
      chk("t5_p1_seqc", 32'(seq_cnt_o), 32'd0);
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd4; rqst_gtr_i = 1'b0;
      tick(); rqst_valid_i = 1'b0; pipeCycle_begin_i = 1'b1;
      tick(); pipeCycle_begin_i = 1'b0; #1;
      chk("t5_p2_pipe", 32'(pipe_cycle_cnt_o), 32'd2);
      chk("t5_p2_seqc", 32'(seq_cnt_o), 32'd1);
      pipeCycle_begin_i = 1'b1;
      tick(); pipeCycle_begin_i = 1'b0; #1;
      chk("t5_p3_pipe", 32'(pipe_cycle_cnt_o), 32'd3);
      chk("t5_p3_seqc", 32'(seq_cnt_o), 32'd0);
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd8; rqst_gtr_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 6) chk("t5_seqc6", 32'(seq_cnt_o), 32'd6);
      end
      chk("t5_seqc7", 32'(seq_cnt_o), 32'd7);
      rqst_valid_i = 1'b0;
      tick();
      chk("t5_seqc_sat", 32'(seq_cnt_o), 32'd7);
      chk("t5_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t5_pipe_hold", 32'(pipe_cycle_cnt_o), 32'd3);

      // Test 6: reset while in SEQ1
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd9; rqst_gtr_i = 1'b1;
      tick(); rqst_valid_i = 1'b0;
      tick();
      chk_alloc("t6_s1", 1'b1, 5'd25, 1'b1, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_alloc("t6_rst", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk("t6_rst_rdy", 32'(rqst_ready_o), 32'd0);
      chk("t6_rst_pipe", 32'(pipe_cycle_cnt_o), 32'd0);
      chk("t6_rst_seqc", 32'(seq_cnt_o), 32'd0);
      rst = 1'b0; #1;
      chk("t6_idle_rdy", 32'(rqst_ready_o), 32'd1);
      tick();
      chk("t6_no_partial", 32'(alloc_valid_o), 32'd0);
      rqst_valid_i = 1'b1; rqst_shift_i = 5'd3; rqst_gtr_i = 1'b0;
      tick(); rqst_valid_i = 1'b0; #1;
      chk_alloc("t6_rq", 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
      tick();
      chk("t6_idle_valid", 32'(alloc_valid_o), 32'd0);
      chk("t6_seqc", 32'(seq_cnt_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/memshare_alloc_sched.md
Name: memshare_alloc_sched

Overview:
- Allocation-sequence scheduler for SCU.memShare(); sits directly upstream of memShare_monitor.
- Accepts shift requests, issues one or two allocation sequences per request to the bank-access stage, and drives the monitor's isGtr_i.
- Consumes the monitor's is_drc_o and pipeCycle_begin_o to insert DRC2 bubbles and track pipeline cycles.

Parameters:
- SHIFT_W, 5, width of the circular-shift factor.
- CNT_W, 8, width of the pipeline-cycle counter.
- SEQ_CNT_W, 3, width of the per-pipeline-cycle sequence counter.

Ports:
- sys_clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rqst_valid_i  in  1  request valid.
- rqst_ready_o  out  1  request ready.
- rqst_shift_i  in  SHIFT_W  shift factor of the request.
- rqst_gtr_i  in  1  request needs two allocation sequences.
- alloc_valid_o  out  1  allocation sequence valid.
- alloc_ready_i  in  1  allocation sequence accepted by the downstream bank stage.
- alloc_shift_o  out  SHIFT_W  shift applied by the current sequence.
- alloc_seq_o  out  1  0 = first sequence, 1 = second sequence.
- alloc_last_o  out  1  last sequence of the current request.
- isGtr_o  out  1  one-cycle pulse to memShare_monitor.isGtr_i.
- is_drc_i  in  MEMSHARE_DRC_NUM  from memShare_monitor.is_drc_o.
- pipeCycle_begin_i  in  1  from memShare_monitor.pipeCycle_begin_o.
- pipe_cycle_cnt_o  out  CNT_W  count of pipeline cycles begun.
- seq_cnt_o  out  SEQ_CNT_W  sequences issued since the last pipeline-cycle begin.

Behaviour:
- Reset: state=IDLE. All outputs 0, counters 0, request register cleared. Reset asserted mid-operation discards the held request, with no partial sequence emitted afterwards.
- Request register: holds {shift, gtr}. Loaded on rqst_valid_i & rqst_ready_o.
- rqst_ready_o is combinational:
  - 1 in IDLE.
  - In SHIFT_GEN: alloc_ready_i & ~gtr.
  - In SEQ1: alloc_ready_i & ~is_drc_i[MEMSHARE_DRC2].
  - 0 in BUBBLE.
- FSM states IDLE, SHIFT_GEN, SEQ1, BUBBLE:
  - IDLE: on request handshake, load the register and go to SHIFT_GEN the next cycle. alloc_valid_o=0.
  - SHIFT_GEN: alloc_valid_o=1, alloc_seq_o=0, alloc_shift_o=shift, alloc_last_o=~gtr. On alloc handshake:
    - gtr=1: go to SEQ1.
    - gtr=0 with a simultaneous new request handshake: reload and stay in SHIFT_GEN (back-to-back, no bubble).
    - otherwise: go to IDLE.
  - SEQ1: alloc_valid_o=1, alloc_seq_o=1, alloc_last_o=1, alloc_shift_o = (shift + 2^(SHIFT_W-1)) mod 2^SHIFT_W. On alloc handshake:
    - is_drc_i[MEMSHARE_DRC2]=1: go to BUBBLE.
    - else a new request handshake: go to SHIFT_GEN.
    - else: go to IDLE.
  - BUBBLE: exactly one cycle, nothing issued, then IDLE.
- isGtr_o = 1 for exactly the cycle of the SHIFT_GEN alloc handshake when gtr=1; otherwise 0. The monitor registers it (one-cycle latency there).
- While alloc_valid_o=1 and alloc_ready_i=0: alloc_shift_o, alloc_seq_o and alloc_last_o hold stable and the state holds.
- pipe_cycle_cnt_o: +1 on every pipeCycle_begin_i; wraps at 2^CNT_W.
- seq_cnt_o: +1 per alloc handshake, saturating at 2^SEQ_CNT_W-1.
  - On pipeCycle_begin_i it loads 1 if a handshake coincides, else 0.
- is_drc_i[MEMSHARE_DRC1] and [MEMSHARE_DRC3] are not used for control; DRC3 reaches the block only as pipeCycle_begin_i.
- Request latency: handshake at cycle t gives the first alloc_valid_o at t+1.

Decomposition:
- memShare_config_pkg gains:
  - typedef enum memshare_sched_state_e {IDLE, SHIFT_GEN, SEQ1, BUBBLE}.
  - struct memshare_rqst_t {shift, gtr}.
- Reuse the existing MEMSHARE_DRC1/2/3 and MEMSHARE_DRC_NUM constants.
- One natural sub-module: memshare_cycle_cnt, which holds the pipe_cycle_cnt and seq_cnt counters with clear/saturate logic. The FSM stays in the top.

Test Plan:
1. Non-gtr request, shift=3, alloc_ready_i=1 → next cycle alloc_valid_o=1, seq=0, shift=3, last=1; isGtr_o stays 0; block returns to IDLE.
2. Gtr request, shift=3 (SHIFT_W=5) → seq0 with shift=3 and isGtr_o pulse in that cycle; next cycle seq1 with shift=19, last=1.
3. Gtr request with is_drc_i[MEMSHARE_DRC2]=1 during the SEQ1 handshake, next request already valid → one cycle with alloc_valid_o=0 and rqst_ready_o=0, then normal resume.
4. alloc_ready_i held 0 for 3 cycles in SEQ1 → outputs stable (seq=1, shift=19); rqst_ready_o=0; no duplicate isGtr_o.
5. pipeCycle_begin_i pulsed 3 times, one coinciding with an alloc handshake → pipe_cycle_cnt_o=3 and seq_cnt_o=1 after the coinciding pulse; 8 handshakes with no pulse saturate seq_cnt_o at 7.
6. rst asserted while in SEQ1 → next cycle all outputs 0, state IDLE; a following request behaves exactly as in test 1.
